// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: default widths, burst/response encodings and the
// initiator state type.
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } axi_mst_state_e;

    // Responses are ordered by severity, so merging is a plain maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master.sv
// Single-outstanding AXI4 initiator: one INCR write (AW/W/B) or read (AR/R)
// at a time, with pass-through data streams and a merged completion response.
module axi_master
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = axi_pkg::AXI_ADDR_BITS,
    parameter int DATA_BITS = axi_pkg::AXI_DATA_BITS,
    parameter int LEN_BITS  = axi_pkg::AXI_LEN_BITS,
    parameter int SIZE_BITS = axi_pkg::AXI_SIZE_BITS
) (
    input  logic                   aclk,
    input  logic                   areset_n,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [LEN_BITS-1:0]    cmd_len,

    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [DATA_BITS-1:0]   wd_data,

    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_last,

    output logic                   done_valid,
    output logic [1:0]             done_resp,

    output logic                   aw_valid,
    input  logic                   aw_ready,
    output logic [ADDR_BITS-1:0]   aw_addr,
    output logic [LEN_BITS-1:0]    aw_len,
    output logic [SIZE_BITS-1:0]   aw_size,
    output logic [1:0]             aw_burst,
    output logic [3:0]             aw_cache,

    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [DATA_BITS-1:0]   w_data,
    output logic [DATA_BITS/8-1:0] w_strb,
    output logic                   w_last,

    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [1:0]             b_resp,

    output logic                   ar_valid,
    input  logic                   ar_ready,
    output logic [ADDR_BITS-1:0]   ar_addr,
    output logic [LEN_BITS-1:0]    ar_len,
    output logic [SIZE_BITS-1:0]   ar_size,
    output logic [1:0]             ar_burst,
    output logic [3:0]             ar_cache,

    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [DATA_BITS-1:0]   r_data,
    input  logic                   r_last,
    input  logic [1:0]             r_resp
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam logic [SIZE_BITS-1:0] BEAT_SIZE = SIZE_BITS'($clog2(STRB_BITS));

    axi_mst_state_e      state;
    axi_mst_state_e      state_next;
    logic [LEN_BITS-1:0] beat_cnt;
    logic [1:0]          resp_acc;

    logic                cmd_fire;
    logic                w_fire;
    logic                b_fire;
    logic                r_fire;
    logic                beats_zero;
    logic [1:0]          r_resp_eff;

    assign aw_size  = BEAT_SIZE;
    assign aw_burst = BURST_INCR;
    assign aw_cache = 4'b0000;
    assign ar_size  = BEAT_SIZE;
    assign ar_burst = BURST_INCR;
    assign ar_cache = 4'b0000;
    assign w_strb   = '1;

    assign beats_zero = (beat_cnt == '0);
    assign cmd_fire   = (state == IDLE)    && cmd_valid;
    assign w_fire     = (state == WR_DATA) && wd_valid && w_ready;
    assign b_fire     = (state == WR_RESP) && b_valid;
    assign r_fire     = (state == RD_DATA) && r_valid && rd_ready;

    // A last flag that disagrees with the beat count (early or overrun) is a slave error.
    assign r_resp_eff = (r_last != beats_zero) ? resp_max(r_resp, RESP_SLVERR) : r_resp;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        w_valid    = 1'b0;
        wd_ready   = 1'b0;
        w_data     = '0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        rd_valid   = 1'b0;
        r_ready    = 1'b0;
        rd_data    = '0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        done_resp  = 2'b00;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_valid && aw_ready) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                w_valid  = wd_valid;
                wd_ready = w_ready;
                w_data   = wd_data;
                w_last   = beats_zero;
                if (w_fire && beats_zero) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_next = DONE;
                end
            end
            RD_ADDR: begin
                if (ar_valid && ar_ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rd_valid = r_valid;
                r_ready  = rd_ready;
                rd_data  = r_data;
                rd_last  = r_last;
                if (r_fire && r_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                done_resp  = resp_acc;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address payloads stay registered and stable until their handshake.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            beat_cnt <= '0;
            resp_acc <= 2'b00;
            aw_valid <= 1'b0;
            aw_addr  <= '0;
            aw_len   <= '0;
            ar_valid <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
        end else begin
            if (cmd_fire) begin
                beat_cnt <= cmd_len;
                resp_acc <= RESP_OKAY;
                if (cmd_write) begin
                    aw_valid <= 1'b1;
                    aw_addr  <= cmd_addr;
                    aw_len   <= cmd_len;
                end else begin
                    ar_valid <= 1'b1;
                    ar_addr  <= cmd_addr;
                    ar_len   <= cmd_len;
                end
            end
            if (aw_valid && aw_ready) begin
                aw_valid <= 1'b0;
            end
            if (ar_valid && ar_ready) begin
                ar_valid <= 1'b0;
            end
            if (w_fire) begin
                beat_cnt <= beat_cnt - LEN_BITS'(1);
            end
            if (b_fire) begin
                resp_acc <= b_resp;
            end
            if (r_fire) begin
                beat_cnt <= beat_cnt - LEN_BITS'(1);
                resp_acc <= resp_max(resp_acc, r_resp_eff);
            end
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: the bench acts as command source, data
// endpoints and AXI slave, and tracks a transaction-level phase model.
`timescale 1ns/1ps
module tb_axi_master;

    logic        aclk;
    logic        areset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    axi_master dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int check_count = 0;
    int pass_count  = 0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Transaction-level model: which phase the transfer is in and what it has seen so far.
    typedef enum {M_IDLE, M_AW, M_W, M_B, M_AR, M_R, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [7:0]  m_len = '0, m_beat = '0;
    logic [1:0]  m_resp = '0;
    logic [31:0] m_aw_addr = '0, m_ar_addr = '0;
    logic [7:0]  m_aw_len = '0, m_ar_len = '0;

    logic [31:0] cap_data[$];
    logic        cap_last[$];
    int          cyc = 0;
    int          aw_high = 0;
    logic [7:0]  aw_len_seen = '0;
    logic        ar_prev = 1'b0;
    int          ar_rise_cyc = 0;
    int          done_count = 0;
    int          last_done_cyc = 0;
    logic [1:0]  last_done_resp = '0;

    always @(negedge aclk) begin
        cyc++;
        if (!areset_n) begin
            m_phase   = M_IDLE;
            m_aw_addr = '0;
            m_aw_len  = '0;
            m_ar_addr = '0;
            m_ar_len  = '0;
        end

        check_output("cmd_ready", 64'(cmd_ready), 64'(m_phase == M_IDLE));
        check_output("aw_valid", 64'(aw_valid), 64'(m_phase == M_AW));
        check_output("ar_valid", 64'(ar_valid), 64'(m_phase == M_AR));
        check_output("aw_payload", 64'({aw_addr, aw_len}), 64'({m_aw_addr, m_aw_len}));
        check_output("ar_payload", 64'({ar_addr, ar_len}), 64'({m_ar_addr, m_ar_len}));
        check_output("const_fields",
                     64'({aw_size, aw_burst, aw_cache, ar_size, ar_burst, ar_cache, w_strb}),
                     64'({3'd2, 2'b01, 4'h0, 3'd2, 2'b01, 4'h0, 4'hF}));
        if (m_phase == M_W)
            check_output("w_chan", 64'({w_valid, wd_ready, w_data, w_last}),
                         64'({wd_valid, w_ready, wd_data, m_beat == m_len}));
        else
            check_output("w_chan", 64'({w_valid, wd_ready, w_data, w_last}), 64'(0));
        if (m_phase == M_R)
            check_output("r_chan", 64'({rd_valid, r_ready, rd_data, rd_last}),
                         64'({r_valid, rd_ready, r_data, r_last}));
        else
            check_output("r_chan", 64'({rd_valid, r_ready, rd_data, rd_last}), 64'(0));
        check_output("b_ready", 64'(b_ready), 64'(m_phase == M_B));
        check_output("done", 64'({done_valid, done_resp}),
                     64'((m_phase == M_DONE) ? {1'b1, m_resp} : 3'b000));

        if (aw_valid) begin
            aw_high++;
            aw_len_seen = aw_len;
        end
        if (ar_valid && !ar_prev) ar_rise_cyc = cyc;
        ar_prev = ar_valid;
        if (w_valid && w_ready) begin
            cap_data.push_back(w_data);
            cap_last.push_back(w_last);
        end
        if (rd_valid && rd_ready) begin
            cap_data.push_back(rd_data);
            cap_last.push_back(rd_last);
        end
        if (done_valid) begin
            done_count++;
            last_done_cyc  = cyc;
            last_done_resp = done_resp;
        end

        if (areset_n) begin
            case (m_phase)
                M_IDLE: if (cmd_valid) begin
                    m_len  = cmd_len;
                    m_beat = '0;
                    m_resp = 2'b00;
                    if (cmd_write) begin
                        m_phase = M_AW; m_aw_addr = cmd_addr; m_aw_len = cmd_len;
                    end else begin
                        m_phase = M_AR; m_ar_addr = cmd_addr; m_ar_len = cmd_len;
                    end
                end
                M_AW: if (aw_ready) m_phase = M_W;
                M_W: if (wd_valid && w_ready) begin
                    if (m_beat == m_len) m_phase = M_B;
                    m_beat++;
                end
                M_B: if (b_valid) begin
                    m_resp  = b_resp;
                    m_phase = M_DONE;
                end
                M_AR: if (ar_ready) m_phase = M_R;
                M_R: if (r_valid && rd_ready) begin
                    if (r_resp > m_resp) m_resp = r_resp;
                    if ((r_last != (m_beat == m_len)) && m_resp < 2'b10) m_resp = 2'b10;
                    if (r_last) m_phase = M_DONE;
                    m_beat++;
                end
                M_DONE: m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    task automatic apply_stimulus(input logic write, input logic [31:0] addr, input logic [7:0] len);
        cap_data.delete();
        cap_last.delete();
        aw_high   = 0;
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic serve_write(input int len, input int aw_stall, input bit toggle,
                               input logic [1:0] bresp, input logic [31:0] base);
        int  sent  = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        aw_ready = 1'b0;
        repeat (aw_stall) tick();
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        wd_valid = 1'b1;
        while (sent <= len && guard < 200) begin
            wd_data = base + 32'(sent);
            w_ready = toggle ? phase : 1'b1;
            phase   = ~phase;
            tick();
            if (w_ready) sent++;
            guard++;
        end
        check_output("w_beats_sent", 64'(sent), 64'(len + 1));
        wd_valid = 1'b0;
        w_ready  = 1'b0;
        wd_data  = '0;
        b_valid  = 1'b1;
        b_resp   = bresp;
        tick();
        b_valid  = 1'b0;
        b_resp   = 2'b00;
    endtask

    task automatic serve_read(input int nbeats, input int err_beat, input int stall_at,
                              input logic [31:0] base);
        int got        = 0;
        int guard      = 0;
        int stall_left = 2;
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid  = 1'b1;
        while (got < nbeats && guard < 200) begin
            r_data = base + 32'(got);
            r_last = (got == nbeats - 1);
            r_resp = (got == err_beat) ? 2'b10 : 2'b00;
            if (got == stall_at && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end else begin
                rd_ready = 1'b1;
            end
            tick();
            if (rd_ready) got++;
            guard++;
        end
        check_output("r_beats_sent", 64'(got), 64'(nbeats));
        r_valid  = 1'b0;
        r_last   = 1'b0;
        r_resp   = 2'b00;
        r_data   = '0;
        rd_ready = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_count == start && n < 20) begin
            tick();
            n++;
        end
        check_output("done_seen", 64'(done_count - start), 64'd1);
    endtask

    // Compares the captured beat stream against base+i with last only on the final beat.
    task automatic check_stream(input string name, input int n, input logic [31:0] base);
        check_output({name, "_count"}, 64'(cap_data.size()), 64'(n));
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            check_output($sformatf("%s_data%0d", name, i), 64'(cap_data[i]), 64'(base + 32'(i)));
            check_output($sformatf("%s_last%0d", name, i), 64'(cap_last[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int wr_done_cyc;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 0; wd_data = '0; rd_ready = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
        ar_ready = 0; r_valid = 0; r_data = '0; r_last = 0; r_resp = '0;
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset_n = 1'b1;
        tick();
        check_output("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("rst_aw_addr", 64'(aw_addr), 64'd0);
        check_output("rst_done", 64'({done_valid, done_resp}), 64'd0);

        $display("[TB] single-beat write with AW stall");
        start = done_count;
        apply_stimulus(1'b1, 32'h10, 8'd0);
        serve_write(0, 3, 1'b0, 2'b00, 32'hDEADBEEF);
        wait_done(start);
        check_output("t1_aw_high_cycles", 64'(aw_high), 64'd4);
        check_stream("t1", 1, 32'hDEADBEEF);
        check_output("t1_resp", 64'(last_done_resp), 64'd0);

        $display("[TB] 4-beat write with toggling w_ready");
        start = done_count;
        apply_stimulus(1'b1, 32'h100, 8'd3);
        serve_write(3, 0, 1'b1, 2'b00, 32'h1111_0000);
        wait_done(start);
        check_output("t2_aw_len", 64'(aw_len_seen), 64'd3);
        check_stream("t2", 4, 32'h1111_0000);
        check_output("t2_resp", 64'(last_done_resp), 64'd0);

        $display("[TB] 8-beat read with rd_ready stall");
        start = done_count;
        apply_stimulus(1'b0, 32'h200, 8'd7);
        serve_read(8, -1, 3, 32'hA000_0000);
        wait_done(start);
        check_stream("t3", 8, 32'hA000_0000);
        check_output("t3_resp", 64'(last_done_resp), 64'd0);

        $display("[TB] read with SLVERR on beat 2");
        start = done_count;
        apply_stimulus(1'b0, 32'h300, 8'd3);
        serve_read(4, 1, -1, 32'hB000_0000);
        wait_done(start);
        check_stream("t4", 4, 32'hB000_0000);
        check_output("t4_resp", 64'(last_done_resp), 64'd2);

        $display("[TB] read with early r_last");
        start = done_count;
        apply_stimulus(1'b0, 32'h400, 8'd3);
        serve_read(3, -1, -1, 32'hC000_0000);
        wait_done(start);
        check_stream("t5", 3, 32'hC000_0000);
        check_output("t5_resp", 64'(last_done_resp), 64'd2);

        $display("[TB] read overrunning its length");
        start = done_count;
        apply_stimulus(1'b0, 32'h500, 8'd1);
        serve_read(3, -1, -1, 32'hD000_0000);
        wait_done(start);
        check_stream("t6", 3, 32'hD000_0000);
        check_output("t6_resp", 64'(last_done_resp), 64'd2);

        $display("[TB] back-to-back write then read");
        start = done_count;
        cap_data.delete();
        cap_last.delete();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h600; cmd_len = 8'd1;
        tick();
        cmd_write = 1'b0; cmd_addr = 32'h700; cmd_len = 8'd0;
        serve_write(1, 0, 1'b0, 2'b11, 32'hE000_0000);
        tick();
        tick();
        cmd_valid = 1'b0;
        check_output("t7_wr_done", 64'(done_count - start), 64'd1);
        check_output("t7_wr_resp", 64'(last_done_resp), 64'd3);
        check_stream("t7w", 2, 32'hE000_0000);
        wr_done_cyc = last_done_cyc;
        start = done_count;
        cap_data.delete();
        cap_last.delete();
        serve_read(1, -1, -1, 32'hF000_0000);
        wait_done(start);
        check_output("t7_accept_gap", 64'(ar_rise_cyc - wr_done_cyc), 64'd2);
        check_stream("t7r", 1, 32'hF000_0000);
        check_output("t7_rd_resp", 64'(last_done_resp), 64'd0);

        $display("[TB] reset during write beat 2");
        start = done_count;
        apply_stimulus(1'b1, 32'h800, 8'd3);
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        wd_valid = 1'b1; w_ready = 1'b1; wd_data = 32'hC0;
        tick();
        wd_data = 32'hC1;
        #2 areset_n = 1'b0;
        #1;
        check_output("t8_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("t8_w_outputs", 64'({w_valid, wd_ready, w_last, w_data}), 64'd0);
        check_output("t8_aw", 64'({aw_valid, aw_addr, aw_len}), 64'd0);
        check_output("t8_b_done", 64'({b_ready, done_valid, done_resp}), 64'd0);
        wd_valid = 1'b0; w_ready = 1'b0; wd_data = '0;
        @(posedge aclk);
        #1 areset_n = 1'b1;
        tick();
        tick();
        check_output("t8_no_done", 64'(done_count - start), 64'd0);

        $display("[TB] write after reset");
        start = done_count;
        apply_stimulus(1'b1, 32'h900, 8'd1);
        serve_write(1, 1, 1'b0, 2'b00, 32'h9000_0000);
        wait_done(start);
        check_stream("t9", 2, 32'h9000_0000);
        check_output("t9_resp", 64'(last_done_resp), 64'd0);

        tick();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
